// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with per-register busy scoreboard and a
// sequential post-reset clear engine. Define REGFILE_WRITE_BYPASS_EN to forward writeback data.
module regfile_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREAD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NREAD*XLEN-1:0]     rd_data,
  output logic [NREAD-1:0]          rd_busy,
  input  logic                      wr_en,
  input  logic [$clog2(NREGS)-1:0]  wr_addr,
  input  logic [XLEN-1:0]           wr_data,
  input  logic                      rsv_en,
  input  logic [$clog2(NREGS)-1:0]  rsv_addr,
  output logic                      ready
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             ready_q, ready_d;

  logic [XLEN-1:0]  mem [NREGS];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [XLEN-1:0]  mem_wdata;

  logic wr_live, rsv_live;

  assign wr_live  = (state_q == StRun) && wr_en && (wr_addr != '0);
  assign rsv_live = (state_q == StRun) && rsv_en && (rsv_addr != '0);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    if (reset) begin
      state_d   = StClear;
      clr_idx_d = '0;
      busy_d    = '0;
      ready_d   = 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == LastIdx) begin
            state_d = StRun;
            ready_d = 1'b1;
          end
        end
        StRun: begin
          if (wr_live) busy_d[wr_addr] = 1'b0;
          // Reserve is applied last: it stands for a newer producer than the writeback.
          if (rsv_live) busy_d[rsv_addr] = 1'b1;
        end
        default: state_d = StClear;
      endcase
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    busy_q    <= busy_d;
    ready_q   <= ready_d;
  end

  assign ready = ready_q;

  // Single write port with no reset so the array can map onto block RAM.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!reset) begin
      if (state_q == StClear) begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
      end else if (wr_live) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (state_q == StRun && rd_addr[i*AW +: AW] != '0) begin
        rd_data[i*XLEN +: XLEN] = mem[rd_addr[i*AW +: AW]];
        rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_live && rd_addr[i*AW +: AW] == wr_addr) begin
          rd_data[i*XLEN +: XLEN] = wr_data;
          rd_busy[i]              = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default build plus a 16x64, 4-port instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance: XLEN=32, NREGS=32, NREAD=2.
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en, rsv_en, ready;
  logic [4:0]  wr_addr, rsv_addr;
  logic [31:0] wr_data;

  regfile_mp dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ready    (ready)
  );

  // Swept instance: XLEN=64, NREGS=16, NREAD=4.
  logic [15:0]  rd_addr2;
  logic [255:0] rd_data2;
  logic [3:0]   rd_busy2;
  logic         wr_en2, rsv_en2, ready2;
  logic [3:0]   wr_addr2, rsv_addr2;
  logic [63:0]  wr_data2;

  regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(4)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr2),
    .rd_data  (rd_data2),
    .rd_busy  (rd_busy2),
    .wr_en    (wr_en2),
    .wr_addr  (wr_addr2),
    .wr_data  (wr_data2),
    .rsv_en   (rsv_en2),
    .rsv_addr (rsv_addr2),
    .ready    (ready2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0; rsv_en  = 1'b0; wr_addr  = '0; rsv_addr  = '0; wr_data  = '0;
    wr_en2 = 1'b0; rsv_en2 = 1'b0; wr_addr2 = '0; rsv_addr2 = '0; wr_data2 = '0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic reserve(input logic [4:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  initial begin
    idle();
    rd_addr  = '0;
    rd_addr2 = '0;
    reset    = 1'b1;
    repeat (3) tick();
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_ready2", {63'd0, ready2}, 64'd0);
    rd(5'd9, 5'd0);
    check("rst_busy", {62'd0, rd_busy}, 64'd0);
    check("rst_rdata", rd_data, 64'd0);
    reset = 1'b0;

    // Writes and reserves issued throughout CLEAR must be dropped.
    write(5'd9, 32'h99);
    reserve(5'd9);
    for (int e = 1; e <= 32; e++) begin
      tick();
      check($sformatf("clr_ready_e%0d", e), {63'd0, ready}, {63'd0, e >= 32});
      check($sformatf("clr_ready2_e%0d", e), {63'd0, ready2}, {63'd0, e >= 16});
      if (e == 32) idle();
    end

    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      check($sformatf("clr_zero_x%0d", a), rd_data, 64'd0);
      check($sformatf("clr_busy_x%0d", a), {62'd0, rd_busy}, 64'd0);
    end

    // Basic write/read and x0.
    write(5'd5, 32'hDEADBEEF); tick();
    write(5'd0, 32'h12345678); tick();
    idle();
    rd(5'd5, 5'd0);
    check("wr_x5", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    check("wr_x0", {32'd0, rd_data[63:32]}, 64'd0);

    // Scoreboard.
    reserve(5'd7); tick(); idle();
    tick(); tick();
    rd(5'd7, 5'd5);
    check("sb_rsv_x7", {62'd0, rd_busy}, 64'd1);
    write(5'd7, 32'h55); tick(); idle();
    rd(5'd7, 5'd0);
    check("sb_wb_busy", {62'd0, rd_busy}, 64'd0);
    check("sb_wb_data", {32'd0, rd_data[31:0]}, 64'h55);
    write(5'd7, 32'h66); reserve(5'd7); tick(); idle();
    rd(5'd7, 5'd0);
    check("sb_same_busy", {62'd0, rd_busy}, 64'd1);
    check("sb_same_data", {32'd0, rd_data[31:0]}, 64'h66);
    write(5'd7, 32'h77); reserve(5'd8); tick(); idle();
    rd(5'd7, 5'd8);
    check("sb_diff_busy", {62'd0, rd_busy}, 64'h2);
    check("sb_diff_data", {32'd0, rd_data[31:0]}, 64'h77);
    reserve(5'd0); tick(); idle();
    rd(5'd0, 5'd8);
    check("sb_rsv_x0", {62'd0, rd_busy}, 64'h2);

    // Same-cycle read of the register being written.
    write(5'd3, 32'h1); tick(); idle();
    write(5'd3, 32'hABCD); reserve(5'd3);
    rd(5'd3, 5'd3);
`ifdef REGFILE_WRITE_BYPASS_EN
    check("byp_data", rd_data, {32'hABCD, 32'hABCD});
`else
    check("byp_data", rd_data, {32'h1, 32'h1});
`endif
    check("byp_busy", {62'd0, rd_busy}, 64'd0);
    tick(); idle();
    rd(5'd3, 5'd0);
    check("byp_after_data", {32'd0, rd_data[31:0]}, 64'hABCD);
    check("byp_after_busy", {62'd0, rd_busy}, 64'd1);

    // Parameter sweep instance: four distinct reads in one cycle.
    wr_en2 = 1'b1; wr_addr2 = 4'd1; wr_data2 = 64'h1111_2222_3333_4444; tick();
    wr_addr2 = 4'd2; wr_data2 = 64'h5555_6666_7777_8888; tick();
    wr_addr2 = 4'd15; wr_data2 = 64'h9999_AAAA_BBBB_CCCC; tick();
    wr_addr2 = 4'd0; wr_data2 = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    wr_en2 = 1'b0;
    rd_addr2 = {4'd0, 4'd1, 4'd2, 4'd15};
    #1;
    check("p2_port0", rd_data2[63:0], 64'h9999_AAAA_BBBB_CCCC);
    check("p2_port1", rd_data2[127:64], 64'h5555_6666_7777_8888);
    check("p2_port2", rd_data2[191:128], 64'h1111_2222_3333_4444);
    check("p2_port3", rd_data2[255:192], 64'd0);

    // Reset mid-run.
    reserve(5'd9); tick(); idle();
    write(5'd9, 32'h9); reserve(5'd10); tick(); idle();
    rd(5'd9, 5'd10);
    check("mr_pre_data", {32'd0, rd_data[31:0]}, 64'h9);
    check("mr_pre_busy", {62'd0, rd_busy}, 64'h2);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mr_ready", {63'd0, ready}, 64'd0);
    write(5'd9, 32'hBAD); reserve(5'd10);
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e == 31) check("mr_ready_e31", {63'd0, ready}, 64'd0);
      if (e == 32) begin
        check("mr_ready_e32", {63'd0, ready}, 64'd1);
        idle();
      end
    end
    rd(5'd9, 5'd10);
    check("mr_x9_data", {32'd0, rd_data[31:0]}, 64'd0);
    check("mr_busy", {62'd0, rd_busy}, 64'd0);
    rd(5'd7, 5'd3);
    check("mr_x7_x3", rd_data, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file with a per-register busy scoreboard.
- Used by the pipelined core in the decode stage: supplies operands and the hazard status of each operand.
- Register 0 is hard-wired to zero. Data width, register count and read-port count are configurable.
- After reset, a sequential clear engine zeroes the array one entry per cycle, so the array maps onto block RAM without a parallel reset.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, minimum 2.
- NREAD, 2, number of read ports; range 1..4.
- Localparam AW = $clog2(NREGS), the address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset; synchronous, active-high.
- rd_addr  input  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  output  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  output  NREAD  busy flag of the register addressed on each read port.
- wr_en  input  1  write enable (writeback).
- wr_addr  input  AW  write address.
- wr_data  input  XLEN  write data.
- rsv_en  input  1  reserve request; marks the destination register busy at issue.
- rsv_addr  input  AW  address to reserve.
- ready  output  1  high once the clear sequence has completed.

Behaviour:
- State machine has two states: CLEAR and RUN.
- Reset (synchronous) takes effect at the next edge:
  - state <= CLEAR; clr_idx <= 0; busy[NREGS-1:0] <= 0; ready <= 0.
  - Array contents are not reset in parallel.
- CLEAR state:
  - Each cycle: mem[clr_idx] <= 0 and clr_idx increments.
  - In the cycle clr_idx == NREGS-1, the final entry is written and state <= RUN, ready <= 1.
  - ready therefore rises NREGS cycles after the first non-reset edge; with the defaults this is the 32nd edge.
  - wr_en and rsv_en are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- Reset asserted mid-operation, in either state, restarts CLEAR from index 0 and clears all busy bits.
- RUN state, read side:
  - Reads are combinational (asynchronous): rd_data[i] = mem[rd_addr[i]].
  - A read of address 0 returns 0 regardless of memory contents.
  - rd_busy[i] = busy[rd_addr[i]].
  - busy[0] is constant 0.
- RUN state, write side:
  - wr_en with wr_addr != 0: mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - Writes to address 0 are dropped.
- RUN state, reserve side:
  - rsv_en with rsv_addr != 0: busy[rsv_addr] <= 1.
  - Reserving address 0 has no effect.
- Simultaneous wr_en and rsv_en to the same nonzero address in one cycle:
  - The data is written.
  - busy ends at 1, because the reserve represents a newer producer and wins.
- Simultaneous wr_en and rsv_en to different addresses: both take effect independently.
- Reserving an already-busy register keeps it busy; no error is flagged.
- Writing a non-busy register is legal: data is written and busy stays 0.
- Without the optional feature, a read of an address being written in the same cycle returns the old value and the old busy flag; the new value is visible on the next cycle.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - In RUN, for any port i with wr_en && wr_addr != 0 && rd_addr[i] == wr_addr, rd_data[i] = wr_data and rd_busy[i] = 0 in the same cycle.
  - If rsv_en targets the same address in that cycle, rd_busy[i] is still 0 this cycle; the reserve shows on the next cycle.
  - Applies to every read port simultaneously.
- Undefined: no forwarding path; reads show the pre-write state, as stated under Behaviour.

Test Plan:
- Clear sequence: hold reset for 3 cycles then release, defaults (NREGS=32) -> ready = 0 for the first 31 edges and 1 after the 32nd; every register then reads 0.
- Basic write/read and x0: write x5 = 0xDEADBEEF, write x0 = 0x12345678 -> next cycle, port 0 at addr 5 reads 0xDEADBEEF and port 1 at addr 0 reads 0.
- Scoreboard: reserve x7, then wait 2 cycles -> rd_busy = 1 for addr 7. Write x7 = 0x55 -> next cycle rd_busy = 0 and data reads 0x55. Write and reserve x7 in the same cycle -> busy = 1 afterward.
- Bypass, build with REGFILE_WRITE_BYPASS_EN: x3 holds 0x1; same-cycle write x3 = 0xABCD while reading addr 3 -> rd_data = 0xABCD, rd_busy = 0. Without the macro -> rd_data = 0x1.
- Reset mid-run: reserve x9, write x9 = 0x9, assert reset for 1 cycle -> ready = 0, busy cleared; after 32 cycles, x9 reads 0. Writes issued during CLEAR are dropped.
- Parameter sweep: NREGS=16, NREAD=4, XLEN=64 -> clear completes in 16 cycles; all 4 ports read distinct registers correctly in the same cycle.
